// File: rtl/ram_load_controller.sv
// rtl/ram_load_controller.sv - RAM write-port mux between CPU bus and byte-stream program loader
//
// Purpose:
//   Owns the address/write port of the single-port program/data RAM. In normal
//   run the CPU bus passes straight through. While loading, a valid/ready byte
//   stream writes consecutive words from address 0, the CPU is held, and a
//   word count and modular checksum of the load are reported.
//
// Ports:
//   mclk              system clock
//   i_reset           synchronous active-high reset (ignores mclk_en)
//   mclk_en           clock enable gating every state update
//   i_cpu_address     CPU RAM address
//   i_cpu_load_enable CPU write request
//   i_cpu_load_data   CPU write data
//   i_prog_start      enter load mode (from run only)
//   i_prog_stop       end load early
//   i_prog_valid      loader byte valid
//   i_prog_data       loader byte
//   o_prog_ready      loader byte accepted when valid & ready
//   o_prog_done       one mclk_en-cycle pulse after a load completes
//   o_prog_count      words written in current/last load
//   o_checksum        byte sum mod 2^WIDTH of current/last load
//   o_cpu_hold        CPU must stall
//   o_ram_address     RAM address
//   o_ram_load_enable RAM write enable
//   o_ram_load_data   RAM write data

module ram_load_controller #(
   parameter int RAM_DEPTH  = 16,
   parameter int WIDTH      = 8,
   localparam int ADDR_WIDTH = $clog2(RAM_DEPTH)
) (
   input  logic                  mclk,
   input  logic                  i_reset,
   input  logic                  mclk_en,
   input  logic [ADDR_WIDTH-1:0] i_cpu_address,
   input  logic                  i_cpu_load_enable,
   input  logic [WIDTH-1:0]      i_cpu_load_data,
   input  logic                  i_prog_start,
   input  logic                  i_prog_stop,
   input  logic                  i_prog_valid,
   input  logic [WIDTH-1:0]      i_prog_data,
   output logic                  o_prog_ready,
   output logic                  o_prog_done,
   output logic [ADDR_WIDTH:0]   o_prog_count,
   output logic [WIDTH-1:0]      o_checksum,
   output logic                  o_cpu_hold,
   output logic [ADDR_WIDTH-1:0] o_ram_address,
   output logic                  o_ram_load_enable,
   output logic [WIDTH-1:0]      o_ram_load_data
);

   localparam logic [1:0] ST_RUN  = 2'd0;
   localparam logic [1:0] ST_LOAD = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(RAM_DEPTH - 1);
   localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);
   localparam logic [ADDR_WIDTH:0]   COUNT_ONE = (ADDR_WIDTH + 1)'(1);

   logic [1:0]            state;
   logic [ADDR_WIDTH-1:0] addr;
   logic [ADDR_WIDTH:0]   count;
   logic [WIDTH-1:0]      checksum;
   logic                  done_q;
   logic                  accept;
   logic                  last_word;

   // Port mux. Ready follows mclk_en so a byte is only taken on an edge where
   // the registers (and the RAM write) actually advance.
   always_comb begin
      o_prog_ready      = 1'b0;
      o_cpu_hold        = 1'b0;
      o_ram_address     = i_cpu_address;
      o_ram_load_enable = i_cpu_load_enable;
      o_ram_load_data   = i_cpu_load_data;
      accept            = 1'b0;
      case (state)
         ST_LOAD: begin
            o_cpu_hold        = 1'b1;
            o_prog_ready      = mclk_en;
            accept            = i_prog_valid & mclk_en;
            o_ram_address     = addr;
            o_ram_load_enable = accept;
            o_ram_load_data   = i_prog_data;
         end
         ST_DONE: begin
            o_cpu_hold        = 1'b1;
            o_ram_address     = addr;
            o_ram_load_enable = 1'b0;
            o_ram_load_data   = i_prog_data;
         end
         default: ;
      endcase
   end

   assign last_word = (addr == LAST_ADDR);

   always_ff @(posedge mclk) begin
      if (i_reset) begin
         state    <= ST_RUN;
         addr     <= '0;
         count    <= '0;
         checksum <= '0;
         done_q   <= 1'b0;
      end else if (mclk_en) begin
         // The pulse is raised on the same edge that leaves DONE, so the CPU
         // sees done and its release together.
         done_q <= (state == ST_DONE);
         case (state)
            ST_RUN: begin
               if (i_prog_start) begin
                  state    <= ST_LOAD;
                  addr     <= '0;
                  count    <= '0;
                  checksum <= '0;
               end
            end
            ST_LOAD: begin
               if (accept) begin
                  count    <= count + COUNT_ONE;
                  checksum <= checksum + i_prog_data;
                  // Wrap explicitly so a non power-of-two depth never runs past the end.
                  addr     <= last_word ? '0 : addr + ADDR_ONE;
               end
               // Stop with a simultaneous accept still writes that byte above.
               if ((accept && last_word) || i_prog_stop)
                  state <= ST_DONE;
            end
            ST_DONE: state <= ST_RUN;
            default: state <= ST_RUN;
         endcase
      end
   end

   assign o_prog_done  = done_q;
   assign o_prog_count = count;
   assign o_checksum   = checksum;

endmodule

// File: tb/tb_ram_load_controller.sv
// tb/tb_ram_load_controller.sv - self-checking bench for ram_load_controller

module tb_ram_load_controller;

   logic       mclk = 1'b0;
   logic       i_reset;
   logic       mclk_en;
   logic [3:0] i_cpu_address;
   logic       i_cpu_load_enable;
   logic [7:0] i_cpu_load_data;
   logic       i_prog_start;
   logic       i_prog_stop;
   logic       i_prog_valid;
   logic [7:0] i_prog_data;
   logic       o_prog_ready;
   logic       o_prog_done;
   logic [4:0] o_prog_count;
   logic [7:0] o_checksum;
   logic       o_cpu_hold;
   logic [3:0] o_ram_address;
   logic       o_ram_load_enable;
   logic [7:0] o_ram_load_data;

   int n_vec = 0;
   int n_err = 0;
   int n_done = 0;

   logic [7:0] ram [16];

   // reference model state
   int         m_phase = 0;   // 0 run, 1 loading, 2 finishing
   int         m_addr = 0;
   int         m_count = 0;
   int         m_sum = 0;
   int         m_done = 0;
   logic [7:0] exp_ram [16];
   bit         exp_known [16];
   bit         started = 1'b0;

   ram_load_controller dut (
      .mclk              (mclk),
      .i_reset           (i_reset),
      .mclk_en           (mclk_en),
      .i_cpu_address     (i_cpu_address),
      .i_cpu_load_enable (i_cpu_load_enable),
      .i_cpu_load_data   (i_cpu_load_data),
      .i_prog_start      (i_prog_start),
      .i_prog_stop       (i_prog_stop),
      .i_prog_valid      (i_prog_valid),
      .i_prog_data       (i_prog_data),
      .o_prog_ready      (o_prog_ready),
      .o_prog_done       (o_prog_done),
      .o_prog_count      (o_prog_count),
      .o_checksum        (o_checksum),
      .o_cpu_hold        (o_cpu_hold),
      .o_ram_address     (o_ram_address),
      .o_ram_load_enable (o_ram_load_enable),
      .o_ram_load_data   (o_ram_load_data)
   );

   always #5 mclk = ~mclk;

   // RAM attached to the controller's write port
   always @(posedge mclk)
      if (mclk_en && o_ram_load_enable)
         ram[o_ram_address] <= o_ram_load_data;

   task automatic check(input string name, input int act, input int exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Compare process: check outputs mid-cycle, then advance the model with the
   // inputs that will be sampled at the next rising edge.
   initial begin
      for (int i = 0; i < 16; i++) exp_known[i] = 1'b0;
      forever begin
         @(negedge mclk);
         if (started) begin
            check("hold", int'(o_cpu_hold), int'(m_phase != 0));
            check("ready", int'(o_prog_ready), int'(m_phase == 1 && mclk_en));
            check("done", int'(o_prog_done), m_done);
            check("count", int'(o_prog_count), m_count);
            check("checksum", int'(o_checksum), m_sum);
            if (m_phase == 0) begin
               check("ram_addr_run", int'(o_ram_address), int'(i_cpu_address));
               check("ram_le_run", int'(o_ram_load_enable), int'(i_cpu_load_enable));
               check("ram_data_run", int'(o_ram_load_data), int'(i_cpu_load_data));
            end else begin
               check("ram_addr_load", int'(o_ram_address), m_addr);
               check("ram_le_load", int'(o_ram_load_enable),
                     int'(m_phase == 1 && i_prog_valid && mclk_en));
               if (m_phase == 1)
                  check("ram_data_load", int'(o_ram_load_data), int'(i_prog_data));
            end
            for (int i = 0; i < 16; i++)
               if (exp_known[i]) check($sformatf("ram[%0d]", i), int'(ram[i]), int'(exp_ram[i]));
            if (o_prog_done && mclk_en) n_done++;
         end

         if (mclk_en) begin
            if (m_phase == 0 && i_cpu_load_enable) begin
               exp_ram[i_cpu_address] = i_cpu_load_data;
               exp_known[i_cpu_address] = 1'b1;
            end
            if (m_phase == 1 && i_prog_valid) begin
               exp_ram[m_addr] = i_prog_data;
               exp_known[m_addr] = 1'b1;
            end
         end

         if (i_reset) begin
            m_phase = 0; m_addr = 0; m_count = 0; m_sum = 0; m_done = 0;
            started = 1'b1;
         end else if (mclk_en) begin
            m_done = (m_phase == 2) ? 1 : 0;
            if (m_phase == 0) begin
               if (i_prog_start) begin
                  m_phase = 1; m_addr = 0; m_count = 0; m_sum = 0;
               end
            end else if (m_phase == 1) begin
               if (i_prog_valid) begin
                  m_sum = (m_sum + int'(i_prog_data)) % 256;
                  m_count = m_count + 1;
                  if (m_addr == 15) begin
                     m_addr = 0;
                     m_phase = 2;
                  end else begin
                     m_addr = m_addr + 1;
                  end
               end
               if (i_prog_stop) m_phase = 2;
            end else begin
               m_phase = 0;
            end
         end
      end
   end

   task automatic cycle();
      @(posedge mclk);
      #1;
   endtask

   task automatic start_load();
      i_prog_start = 1'b1;
      cycle();
      i_prog_start = 1'b0;
   endtask

   task automatic finish_with_stop();
      i_prog_valid = 1'b0;
      i_prog_stop = 1'b1;
      cycle();
      i_prog_stop = 1'b0;
      cycle();
      cycle();
   endtask

   initial begin
      int d0;
      i_reset = 1'b1; mclk_en = 1'b1;
      i_cpu_address = '0; i_cpu_load_enable = 1'b0; i_cpu_load_data = '0;
      i_prog_start = 1'b0; i_prog_stop = 1'b0; i_prog_valid = 1'b0; i_prog_data = '0;
      cycle();
      cycle();
      check("reset_count", int'(o_prog_count), 0);
      check("reset_hold", int'(o_cpu_hold), 0);
      i_reset = 1'b0;

      // 1: CPU write in run mode
      i_cpu_address = 4'd5; i_cpu_load_enable = 1'b1; i_cpu_load_data = 8'h3C;
      cycle();
      i_cpu_load_enable = 1'b0;
      check("t1_ram5", int'(ram[5]), 8'h3C);
      check("t1_hold", int'(o_cpu_hold), 0);
      check("t1_ready", int'(o_prog_ready), 0);

      // 2: full 16-byte load
      d0 = n_done;
      start_load();
      check("t2_ready_after_start", int'(o_prog_ready), 1);
      i_prog_valid = 1'b1;
      for (int i = 0; i < 16; i++) begin
         i_prog_data = 8'(i + 1);
         cycle();
      end
      i_prog_valid = 1'b0;
      check("t2_hold_in_done", int'(o_cpu_hold), 1);
      check("t2_done_not_yet", int'(o_prog_done), 0);
      cycle();
      check("t2_done_pulse", int'(o_prog_done), 1);
      check("t2_hold_released", int'(o_cpu_hold), 0);
      cycle();
      check("t2_done_cleared", int'(o_prog_done), 0);
      check("t2_done_count", n_done - d0, 1);
      check("t2_count", int'(o_prog_count), 16);
      check("t2_checksum", int'(o_checksum), 8'h88);
      for (int i = 0; i < 16; i++) check($sformatf("t2_ram%0d", i), int'(ram[i]), i + 1);

      // 3: short load ended by stop
      start_load();
      i_prog_valid = 1'b1;
      i_prog_data = 8'hFF; cycle();
      i_prog_data = 8'hFF; cycle();
      i_prog_data = 8'h03; cycle();
      finish_with_stop();
      check("t3_count", int'(o_prog_count), 3);
      check("t3_checksum", int'(o_checksum), 8'h01);
      check("t3_ram0", int'(ram[0]), 8'hFF);
      check("t3_ram2", int'(ram[2]), 8'h03);
      check("t3_ram3", int'(ram[3]), 8'h04);
      check("t3_ram15", int'(ram[15]), 8'h10);

      // 4: clock enable toggling while valid is held
      start_load();
      i_prog_valid = 1'b1;
      for (int k = 0; k < 8; k++) begin
         mclk_en = (k % 2 == 0);
         i_prog_data = 8'(8'h20 + k);
         if (k == 1) i_prog_start = 1'b1;
         cycle();
         i_prog_start = 1'b0;
      end
      mclk_en = 1'b1;
      finish_with_stop();
      check("t4_count", int'(o_prog_count), 4);
      check("t4_checksum", int'(o_checksum), 8'h8C);
      check("t4_ram1", int'(ram[1]), 8'h22);
      check("t4_ram3", int'(ram[3]), 8'h26);
      check("t4_ram4", int'(ram[4]), 8'h05);

      // 5: CPU write dropped while loading; stop with accept in the same cycle
      start_load();
      i_cpu_address = 4'd7; i_cpu_load_enable = 1'b1; i_cpu_load_data = 8'hAA;
      cycle();
      i_cpu_load_enable = 1'b0;
      i_prog_valid = 1'b1; i_prog_data = 8'h5A; i_prog_stop = 1'b1;
      cycle();
      i_prog_valid = 1'b0; i_prog_stop = 1'b0;
      check("t5_hold_in_done", int'(o_cpu_hold), 1);
      cycle();
      cycle();
      check("t5_ram7", int'(ram[7]), 8'h08);
      check("t5_ram0", int'(ram[0]), 8'h5A);
      check("t5_count", int'(o_prog_count), 1);
      check("t5_checksum", int'(o_checksum), 8'h5A);

      // 6: reset mid-load with clock enable low
      start_load();
      i_prog_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         i_prog_data = 8'(8'h71 + i);
         cycle();
      end
      i_prog_valid = 1'b0;
      mclk_en = 1'b0;
      i_reset = 1'b1;
      cycle();
      check("t6_hold", int'(o_cpu_hold), 0);
      check("t6_count", int'(o_prog_count), 0);
      check("t6_checksum", int'(o_checksum), 0);
      i_reset = 1'b0;
      mclk_en = 1'b1;
      for (int i = 0; i < 4; i++) check($sformatf("t6_ram%0d", i), int'(ram[i]), 8'h71 + i);
      i_cpu_address = 4'd9; i_cpu_load_enable = 1'b1; i_cpu_load_data = 8'h99;
      cycle();
      i_cpu_load_enable = 1'b0;
      check("t6_run_resumes", int'(ram[9]), 8'h99);
      cycle();
      cycle();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
